// File: rtl/bcd_dabble_serial.sv
// ---------------------------------------------------------------------------
// bcd_dabble_serial
//   Sequential binary -> packed BCD converter (shift-and-add-3), one input bit
//   per clock. Sits between the CPU result bus and the seven-segment scan
//   driver. Valid/ready on both sides; the result is registered and held in
//   HOLD until the sink takes it.
//
// Parameters
//   BIN_W   width of the unsigned binary input
//   DIGITS  number of BCD digits produced (out_bcd is 4*DIGITS wide)
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   source presents in_bin
//   in_ready   converter accepts in_bin this cycle
//   in_bin     unsigned binary value
//   out_valid  out_bcd/out_ovf hold a finished result
//   out_ready  sink consumes the result this cycle
//   out_bcd    packed BCD, digit 0 (ones) in [3:0]
//   out_ovf    value >= 10**DIGITS; out_bcd holds the low DIGITS digits
//   busy       conversion in progress
// ---------------------------------------------------------------------------

// One BCD digit's pre-shift correction: +3 when the digit is 5..9 so that the
// following left shift carries correctly into the next decimal digit.
// 9+3 = 12 still fits in 4 bits, so no carry leaves the nibble.
module bcd_dabble_digit (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_dabble_serial #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    output logic                  busy
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_nxt;
    logic [BCD_W-1:0]   scratch_q, scratch_nxt, adj;
    logic               ovf_q, ovf_bit, ovf_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_hs, out_hs, last_step;

    // Per-digit add-3 correction on the scratch register.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_dabble_digit u_dig (
                .d (scratch_q[4*g +: 4]),
                .q (adj[4*g +: 4])
            );
        end
    endgenerate

    // Shift {adjusted scratch, binary} left by one. The bit leaving the top
    // digit is a lost high decimal digit: it feeds the sticky overflow flag.
    // Lower digits never depend on higher ones, so truncation is harmless to them.
    assign {ovf_bit, scratch_nxt, shift_nxt} = {adj, shift_q, 1'b0};
    assign ovf_nxt   = ovf_q | ovf_bit;
    assign last_step = (cnt_q == CNT_W'(1));

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == CONVERT);
    // Accepting in HOLD requires the sink to take the current result in the
    // same cycle, giving one result per BIN_W+1 cycles when streaming.
    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_hs) state_d = CONVERT;
            CONVERT: if (last_step) state_d = HOLD;
            HOLD:    if (out_hs) state_d = in_valid ? CONVERT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            out_bcd   <= '0;
            out_ovf   <= 1'b0;
        end else if (in_hs) begin
            shift_q   <= in_bin;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= CNT_W'(BIN_W);
        end else if (state_q == CONVERT) begin
            shift_q   <= shift_nxt;
            scratch_q <= scratch_nxt;
            ovf_q     <= ovf_nxt;
            cnt_q     <= cnt_q - CNT_W'(1);
            // Result registers only change on entry to HOLD.
            if (last_step) begin
                out_bcd <= scratch_nxt;
                out_ovf <= ovf_nxt;
            end
        end
    end
endmodule
